// File: rtl/siaminer_pkg.sv
// rtl/siaminer_pkg.sv - shared widths and state encoding for the siaminer nonce source
//
// Purpose : common constants and types used by the siaminer nonce front end.
// Contents: NONCE_W  - width of a nonce / m04 word
//           CNT_W    - width of the per-work nonce count and the issue counter
//           gen_state_t - nonce generator states (IDLE, RUN, DONE)

package siaminer_pkg;

  localparam int NONCE_W = 64;
  localparam int CNT_W   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } gen_state_t;

endpackage

// File: rtl/nonce_gen.sv
// rtl/nonce_gen.sv - nonce source feeding the first siaminer hash pipeline stage
//
// Purpose : on each new-work strobe, loads a start nonce and a count, then issues
//           one m04 word per enabled cycle, stepping by STRIDE, until the count
//           runs out, a nonce is found, or new work replaces the current range.
//           STRIDE/OFFSET let several cores interleave one nonce range.
//
// Parameters:
//   STRIDE  - added to the nonce after every issue (number of interleaved cores)
//   OFFSET  - added to startIn at load (this core's slot in the interleave)
//
// Ports:
//   clk      in   1   clock
//   rst      in   1   asynchronous reset, active-high
//   valid    in   1   new-work strobe; loads startIn/countIn
//   found    in   1   nonce-found strobe; stops issuing
//   en       in   1   issue enable; 0 stalls in place (only meaningful in RUN)
//   startIn  in   64  first nonce of the work range
//   countIn  in   32  number of nonces to issue for this work
//   vldOut   out  1   m04Out carries a fresh nonce this cycle
//   m04Out   out  64  nonce word to the pipeline (holds while vldOut=0)
//   done     out  1   range exhausted; held until next valid or found
//   issCnt   out  32  total nonces issued since reset, wraps mod 2^32

module nonce_gen
  import siaminer_pkg::*;
#(
  parameter logic [NONCE_W-1:0] STRIDE = 64'd1,
  parameter logic [NONCE_W-1:0] OFFSET = 64'd0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid,
  input  logic               found,
  input  logic               en,
  input  logic [NONCE_W-1:0] startIn,
  input  logic [CNT_W-1:0]   countIn,
  output logic               vldOut,
  output logic [NONCE_W-1:0] m04Out,
  output logic               done,
  output logic [CNT_W-1:0]   issCnt
);

  gen_state_t         r_state;
  logic [NONCE_W-1:0] r_nonce;
  logic [CNT_W-1:0]   r_remaining;
  logic               r_vld;
  logic [NONCE_W-1:0] r_m04;
  logic               r_done;
  logic [CNT_W-1:0]   r_iss_cnt;

  // An issue happens only when neither strobe overrides the state action.
  logic w_issue;
  assign w_issue = !valid && !found && (r_state == RUN) &&
                   (r_remaining != '0) && en;

  // State machine and datapath registers. Priority: valid > found > state action.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_nonce     <= '0;
      r_remaining <= '0;
      r_vld       <= 1'b0;
      r_m04       <= '0;
      r_done      <= 1'b0;
    end else if (valid) begin
      // New work wins even over a same-cycle found, which belongs to the old range.
      // vldOut drops for the load cycle so the old range stops cleanly.
      r_state     <= RUN;
      r_nonce     <= startIn + OFFSET;
      r_remaining <= countIn;
      r_vld       <= 1'b0;
      r_done      <= 1'b0;
    end else if (found) begin
      r_state <= IDLE;
      r_vld   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_vld <= 1'b0;
        end
        RUN: begin
          if (r_remaining == '0) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_vld   <= 1'b0;
          end else if (en) begin
            r_vld       <= 1'b1;
            r_m04       <= r_nonce;
            r_nonce     <= r_nonce + STRIDE;  // wraps silently mod 2^64
            r_remaining <= r_remaining - 1'b1;
          end else begin
            r_vld <= 1'b0;
          end
        end
        DONE: begin
          r_vld  <= 1'b0;
          r_done <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_vld   <= 1'b0;
        end
      endcase
    end
  end

  // Lifetime issue counter, wraps mod 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_iss_cnt <= '0;
    end else if (w_issue) begin
      r_iss_cnt <= r_iss_cnt + 1'b1;
    end
  end

  assign vldOut = r_vld;
  assign m04Out = r_m04;
  assign done   = r_done;
  assign issCnt = r_iss_cnt;

endmodule

// File: tb/tb_nonce_gen.sv
// tb/tb_nonce_gen.sv - directed self-checking bench for nonce_gen

module tb_nonce_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        found;
  logic        en;
  logic [63:0] startIn;
  logic [31:0] countIn;

  // u_a: STRIDE=1 OFFSET=0; u_b: STRIDE=4 OFFSET=2, sharing the same stimulus
  logic        a_vld, b_vld, a_done, b_done;
  logic [63:0] a_m04, b_m04;
  logic [31:0] a_cnt, b_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nonce_gen #(.STRIDE(64'd1), .OFFSET(64'd0)) u_a (
    .clk(clk), .rst(rst), .valid(valid), .found(found), .en(en),
    .startIn(startIn), .countIn(countIn),
    .vldOut(a_vld), .m04Out(a_m04), .done(a_done), .issCnt(a_cnt)
  );

  nonce_gen #(.STRIDE(64'd4), .OFFSET(64'd2)) u_b (
    .clk(clk), .rst(rst), .valid(valid), .found(found), .en(en),
    .startIn(startIn), .countIn(countIn),
    .vldOut(b_vld), .m04Out(b_m04), .done(b_done), .issCnt(b_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_issue(input string tag, input logic [63:0] exp_m04);
    chk({tag, "_vld"}, {63'd0, a_vld}, 64'd1);
    chk({tag, "_m04"}, a_m04, exp_m04);
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; found = 1'b0; en = 1'b0;
    startIn = '0; countIn = '0;
    #2;
    chk("rst_vld",  {63'd0, a_vld},  64'd0);
    chk("rst_m04",  a_m04,           64'd0);
    chk("rst_done", {63'd0, a_done}, 64'd0);
    chk("rst_cnt",  {32'd0, a_cnt},  64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("idle_vld", {63'd0, a_vld}, 64'd0);

    // Basic range: 0x100, count 3
    valid = 1'b1; startIn = 64'h100; countIn = 32'd3; en = 1'b1;
    tick();
    valid = 1'b0;
    chk("t1_load_vld", {63'd0, a_vld}, 64'd0);
    tick(); chk_issue("t1_n0", 64'h100);
    tick(); chk_issue("t1_n1", 64'h101);
    tick(); chk_issue("t1_n2", 64'h102);
    chk("t1_b_n2", b_m04, 64'h10A);
    chk("t1_nodone", {63'd0, a_done}, 64'd0);
    tick();
    chk("t1_done", {63'd0, a_done}, 64'd1);
    chk("t1_vld0", {63'd0, a_vld},  64'd0);
    chk("t1_cnt",  {32'd0, a_cnt},  64'd3);
    tick();
    chk("t1_done_hold", {63'd0, a_done}, 64'd1);

    // Wrap with STRIDE=4, OFFSET=2 (instance u_b)
    valid = 1'b1; startIn = 64'hFFFF_FFFF_FFFF_FFFC; countIn = 32'd3;
    tick();
    valid = 1'b0;
    chk("t2_done_clr", {63'd0, b_done}, 64'd0);
    tick();
    chk("t2_n0_vld", {63'd0, b_vld}, 64'd1);
    chk("t2_n0", b_m04, 64'hFFFF_FFFF_FFFF_FFFE);
    tick(); chk("t2_n1", b_m04, 64'h2);
    tick(); chk("t2_n2", b_m04, 64'h6);
    chk("t2_a_n2", a_m04, 64'hFFFF_FFFF_FFFF_FFFE);
    tick();
    chk("t2_done", {63'd0, b_done}, 64'd1);
    chk("t2_cnt",  {32'd0, b_cnt},  64'd6);

    // Throttle: en 1,0,0,1
    valid = 1'b1; startIn = 64'h10; countIn = 32'd2; en = 1'b1;
    tick();
    valid = 1'b0;
    tick(); chk_issue("t3_n0", 64'h10);
    en = 1'b0;
    tick();
    chk("t3_gap0_vld", {63'd0, a_vld}, 64'd0);
    chk("t3_gap0_m04", a_m04, 64'h10);
    tick();
    chk("t3_gap1_vld", {63'd0, a_vld}, 64'd0);
    chk("t3_gap1_m04", a_m04, 64'h10);
    en = 1'b1;
    tick(); chk_issue("t3_n1", 64'h11);
    tick();
    chk("t3_done", {63'd0, a_done}, 64'd1);
    chk("t3_cnt",  {32'd0, a_cnt},  64'd8);

    // Found after two issues of ten
    valid = 1'b1; startIn = 64'h200; countIn = 32'd10;
    tick();
    valid = 1'b0;
    chk("t4_load_done_clr", {63'd0, a_done}, 64'd0);
    tick(); chk_issue("t4_n0", 64'h200);
    tick(); chk_issue("t4_n1", 64'h201);
    found = 1'b1;
    tick();
    found = 1'b0;
    chk("t4_found_vld",  {63'd0, a_vld},  64'd0);
    chk("t4_found_done", {63'd0, a_done}, 64'd0);
    tick();
    tick();
    chk("t4_idle_vld", {63'd0, a_vld},  64'd0);
    chk("t4_idle_m04", a_m04,           64'h201);
    chk("t4_idle_done", {63'd0, a_done}, 64'd0);
    chk("t4_cnt", {32'd0, a_cnt}, 64'd10);
    valid = 1'b1; startIn = 64'h500; countIn = 32'd1;
    tick();
    valid = 1'b0;
    tick(); chk_issue("t4_resume", 64'h500);
    tick();
    chk("t4_resume_done", {63'd0, a_done}, 64'd1);
    chk("t4_resume_cnt",  {32'd0, a_cnt},  64'd11);

    // valid and found together mid-run: load wins
    valid = 1'b1; startIn = 64'h700; countIn = 32'd5;
    tick();
    valid = 1'b0;
    tick(); chk_issue("t5_old", 64'h700);
    valid = 1'b1; found = 1'b1; startIn = 64'h900; countIn = 32'd1;
    tick();
    valid = 1'b0; found = 1'b0;
    chk("t5_load_vld", {63'd0, a_vld}, 64'd0);
    tick(); chk_issue("t5_new", 64'h900);
    tick();
    chk("t5_done", {63'd0, a_done}, 64'd1);
    chk("t5_cnt",  {32'd0, a_cnt},  64'd13);

    // countIn = 0: done two edges after valid, no issue
    valid = 1'b1; startIn = 64'hABC; countIn = 32'd0;
    tick();
    valid = 1'b0;
    chk("t6_load_vld",  {63'd0, a_vld},  64'd0);
    chk("t6_load_done", {63'd0, a_done}, 64'd0);
    tick();
    chk("t6_vld",  {63'd0, a_vld},  64'd0);
    chk("t6_done", {63'd0, a_done}, 64'd1);
    chk("t6_cnt",  {32'd0, a_cnt},  64'd13);

    // Asynchronous reset mid-run
    valid = 1'b1; startIn = 64'h1000; countIn = 32'd8;
    tick();
    valid = 1'b0;
    tick(); chk_issue("t7_n0", 64'h1000);
    tick(); chk_issue("t7_n1", 64'h1001);
    #2;
    rst = 1'b1;
    #1;
    chk("t7_async_vld",  {63'd0, a_vld},  64'd0);
    chk("t7_async_m04",  a_m04,           64'd0);
    chk("t7_async_done", {63'd0, a_done}, 64'd0);
    chk("t7_async_cnt",  {32'd0, a_cnt},  64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("t7_post0_vld", {63'd0, a_vld}, 64'd0);
    tick();
    chk("t7_post1_vld", {63'd0, a_vld}, 64'd0);
    chk("t7_post_m04",  a_m04,          64'd0);
    chk("t7_post_cnt",  {32'd0, a_cnt}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nonce_gen.md
Name: nonce_gen

Overview:
- Nonce source for the siaminer hash pipeline; sits directly upstream of the first pipeline register stage and drives its vldIn/m04In.
- On each new-work strobe, loads a start nonce and a nonce count.
- Then issues one 64-bit m04 word per enabled cycle, stepping by STRIDE, until the count is exhausted, a nonce is found, or new work arrives.
- STRIDE/OFFSET let several cores interleave one nonce range.

Parameters:
STRIDE, 1, increment added to the nonce after each issue (number of interleaved cores)
OFFSET, 0, added to startIn at load (this core's index in the interleave)

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
valid  input  1  new-work strobe; loads startIn/countIn
found  input  1  nonce-found strobe from the result checker; stops issuing
en  input  1  issue enable / throttle; 0 = stall in place
startIn  input  64  first nonce of the work range
countIn  input  32  number of nonces to issue for this work
vldOut  output  1  m04Out carries a fresh nonce this cycle
m04Out  output  64  nonce word to the pipeline
done  output  1  range exhausted; level, held until next valid or found
issCnt  output  32  total nonces issued since reset, wraps mod 2^32

Behaviour:
- Reset (async, immediate): state IDLE, nonce=0, remaining=0, vldOut=0, m04Out=0, done=0, issCnt=0.
- States: IDLE, RUN, DONE. All registers update on posedge clk.
- Priority per edge: rst > valid > found > state action.
- valid=1, any state:
  - nonce <= startIn + OFFSET (mod 2^64); remaining <= countIn.
  - state <= RUN; vldOut <= 0; done <= 0; m04Out holds.
- found=1 (valid=0), any state: state <= IDLE; vldOut <= 0; done <= 0; nonce, remaining and m04Out hold.
- IDLE: vldOut <= 0; no change otherwise.
- RUN, remaining==0: state <= DONE; done <= 1; vldOut <= 0.
- RUN, remaining!=0, en=1 (issue):
  - vldOut <= 1; m04Out <= nonce.
  - nonce <= nonce + STRIDE (mod 2^64; wrap silent, no flag).
  - remaining <= remaining - 1; issCnt <= issCnt + 1.
- RUN, remaining!=0, en=0: vldOut <= 0; nonce, remaining and m04Out hold.
- DONE: vldOut <= 0; done stays 1.
- Latency:
  - First vldOut is 2 edges after the valid-sampling edge: load edge, then first issue edge.
  - Last nonce leaves on the issue edge where remaining goes 1 -> 0.
  - done rises one edge later.
- countIn=0: load, then next edge RUN -> DONE; no nonce issued.
- valid during RUN discards the old range with no further issue of it; vldOut is 0 for the load cycle, which keeps the downstream flush consistent.
- valid and found in the same cycle: new work loads (found belongs to old work).
- en is ignored outside RUN.
- m04Out holds its last value whenever vldOut=0; downstream qualifies with vldOut only.

Decomposition:
- Shared package siaminer_pkg:
  - NONCE_W=64, CNT_W=32.
  - State typedef gen_state_t {IDLE, RUN, DONE}.
- No sub-module; single always block for the state machine plus datapath registers, and a separate issCnt counter block.

Test Plan:
- Reset then valid with startIn=0x100, countIn=3, en=1, STRIDE=1, OFFSET=0 -> vldOut=1 for 3 cycles starting 2 edges after valid, m04Out=0x100,0x101,0x102; done=1 on the next edge; issCnt=3.
- STRIDE=4, OFFSET=2, startIn=0xFFFF_FFFF_FFFF_FFFC, countIn=3 -> m04Out=0xFFFF_FFFF_FFFF_FFFE, 0x2, 0x6 (silent wrap).
- en toggled 1,0,0,1 during RUN, startIn=0x10, countIn=2 -> m04Out=0x10 then 0x11 with two vldOut=0 gap cycles; m04Out holds 0x10 during the gap.
- found asserted after 2 of countIn=10 issued -> vldOut=0 next edge, state IDLE, done=0, no further issue; later valid with startIn=0x500 -> resumes from 0x500.
- valid and found together mid-run with startIn=0x900, countIn=1 -> load wins: one nonce 0x900, then done=1; countIn=0 case -> done=1 two edges after valid, vldOut never 1.
- rst asserted asynchronously mid-RUN -> vldOut, m04Out, done, issCnt go to 0 immediately without a clock edge; no vldOut after rst deasserts until the next valid.
